// File: rtl/div_pkg.sv
// Shared definitions for the subtract-shift divider.
//   state_t : top-level FSM states
//   cnt_w() : iteration counter width for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 32;

    // Counter holds DATA_W-1 down to 0, so clog2(DATA_W) bits suffice.
    function automatic int cnt_w(input int dw);
        return (dw < 2) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/div_subshift_core.sv
// Unsigned iterative restoring divider datapath, one quotient bit per step.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture dvd_mag/dvs_mag and arm the counter
//   step       : perform one subtract-shift iteration (MSB first)
//   dvd_mag    : unsigned dividend magnitude
//   dvs_mag    : unsigned divisor magnitude
//   q_o, r_o   : current quotient / partial remainder
//   last       : the step taken this cycle is the final one
module div_subshift_core
    import div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dvd_mag,
    input  logic [DATA_W-1:0] dvs_mag,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] r_o,
    output logic              last
);

    localparam int CNT_W = cnt_w(DATA_W);

    // The stored remainder is always below the divisor, so it fits in
    // DATA_W bits; the DATA_W+1-bit value only exists as the shifted trial.
    logic [DATA_W-1:0] r_q, r_d;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   trial;

    always_comb begin
        r_d   = r_q;
        q_d   = q_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        trial = {r_q, q_q[DATA_W-1]};
        if (load) begin
            r_d   = '0;
            q_d   = dvd_mag;
            dvs_d = dvs_mag;
            cnt_d = CNT_W'(DATA_W - 1);
        end else if (step) begin
            cnt_d = cnt_q - 1'b1;
            if (trial >= {1'b0, dvs_q}) begin
                r_d = DATA_W'(trial - {1'b0, dvs_q});
                q_d = {q_q[DATA_W-2:0], 1'b1};
            end else begin
                r_d = trial[DATA_W-1:0];
                q_d = {q_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o  = q_q;
    assign r_o  = r_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/div_subshift.sv
// Signed/unsigned restoring divider, DATA_W+2 edges from request to done.
//   clk, rst_n          : clock, synchronous active-low reset
//   en                  : level request; low aborts or returns to idle
//   sign                : 1 = two's-complement, 0 = unsigned
//   dividend, divisor   : operands, captured on the starting edge
//   done                : registered result-valid
//   quotient, remainder : registered results (truncation toward zero)
module div_subshift
    import div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [DATA_W-1:0] dvd_raw_q, dvd_raw_d;
    logic [DATA_W-1:0] dvs_raw_q, dvs_raw_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;

    logic              core_load, core_step, core_last;
    logic [DATA_W-1:0] dvd_mag, dvs_mag, core_q, core_r;

    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly 2^(DATA_W-1) -- the magnitude we want.
    assign dvd_mag = (sign && dividend[DATA_W-1]) ? -dividend : dividend;
    assign dvs_mag = (sign && divisor[DATA_W-1])  ? -divisor  : divisor;

    div_subshift_core #(.DATA_W(DATA_W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (core_load),
        .step    (core_step),
        .dvd_mag (dvd_mag),
        .dvs_mag (dvs_mag),
        .q_o     (core_q),
        .r_o     (core_r),
        .last    (core_last)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dvd_raw_d = dvd_raw_q;
        dvs_raw_d = dvs_raw_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        if (!en) begin
            // Abort from BUSY/FIX or release from DONE; results untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    core_load = 1'b1;
                    sign_d    = sign;
                    qneg_d    = sign && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                    rneg_d    = sign && dividend[DATA_W-1];
                    dvd_raw_d = dividend;
                    dvs_raw_d = divisor;
                    state_d   = S_BUSY;
                end
                S_BUSY: begin
                    core_step = 1'b1;
                    if (core_last) state_d = S_FIX;
                end
                S_FIX: begin
                    if (dvs_raw_q == '0) begin
                        quo_d = '1;
                        rem_d = dvd_raw_q;
                    end else if (sign_q && dvd_raw_q == MIN_VAL && dvs_raw_q == '1) begin
                        quo_d = MIN_VAL;
                        rem_d = '0;
                    end else begin
                        quo_d = qneg_q ? -core_q : core_q;
                        rem_d = rneg_q ? -core_r : core_r;
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    // done registers one edge after entering DONE, giving the
                    // DATA_W+2 latency; held high until en drops.
                    done_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dvd_raw_q <= '0;
            dvs_raw_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dvd_raw_q <= dvd_raw_d;
            dvs_raw_q <= dvs_raw_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_div_subshift.sv
module tb_div_subshift;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, en, sign, done;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    div_subshift #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sign(sign),
        .dividend(dividend), .divisor(divisor),
        .done(done), .quotient(quotient), .remainder(remainder)
    );

    // Reference: plain integer division, truncating toward zero.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = W'(int'(a) / int'(b));
            r = W'(int'(a) % int'(b));
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -(2 ** (W - 1)) && sb == -1) begin
                q = W'(sa);
                r = '0;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end
    endfunction

    task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        sign = s; dividend = a; divisor = b; en = 1'b1;
        @(posedge clk);
    endtask

    // Edges counted after the sampling edge; 99 marks an expired bound.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_en();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        start(s, a, b);
        wait_done(lat);
        q = quotient;
        r = remainder;
        release_en();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sign = 1'b0; dividend = 4'd9; divisor = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset: done=%b q=%h r=%h, want 0 0 0", done, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_latency();
        int lat;
        start(1'b0, 4'd13, 4'd3);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL early_done: done=%b want 0", done);
        end
        wait_done(lat);
        checks++;
        if (lat != 6) begin
            errors++; $display("FAIL latency_13_3: got %0d edges want 6", lat);
        end
        checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1) begin
            errors++; $display("FAIL u13_3: q=%0d r=%0d want 4 1", quotient, remainder);
        end
        // en held high: result stays put, no restart.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
                errors++;
                $display("FAIL hold_%0d: done=%b q=%0d r=%0d want 1 4 1", i, done, quotient, remainder);
            end
        end
        release_en();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL release: done=%b want 0", done);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] q, r;
        int lat;
        do_op(1'b1, 4'b1001, 4'd2, q, r, lat);   // -7 / 2
        checks++;
        if (q !== 4'b1101 || r !== 4'b1111 || lat != 6) begin
            errors++; $display("FAIL s_m7_2: q=%b r=%b lat=%0d want 1101 1111 6", q, r, lat);
        end
        do_op(1'b1, 4'd7, 4'b1110, q, r, lat);   // 7 / -2
        checks++;
        if (q !== 4'b1101 || r !== 4'b0001 || lat != 6) begin
            errors++; $display("FAIL s_7_m2: q=%b r=%b lat=%0d want 1101 0001 6", q, r, lat);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r;
        int lat;
        do_op(1'b0, 4'd9, 4'd0, q, r, lat);
        checks++;
        if (q !== 4'd15 || r !== 4'd9 || lat != 6) begin
            errors++; $display("FAIL u9_0: q=%0d r=%0d lat=%0d want 15 9 6", q, r, lat);
        end
        do_op(1'b1, 4'b1011, 4'd0, q, r, lat);   // -5 / 0
        checks++;
        if (q !== 4'b1111 || r !== 4'b1011 || lat != 6) begin
            errors++; $display("FAIL s_m5_0: q=%b r=%b lat=%0d want 1111 1011 6", q, r, lat);
        end
        do_op(1'b1, 4'b1000, 4'b1111, q, r, lat); // -8 / -1
        checks++;
        if (q !== 4'b1000 || r !== 4'b0000 || lat != 6) begin
            errors++; $display("FAIL s_ovf: q=%b r=%b lat=%0d want 1000 0000 6", q, r, lat);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        start(1'b0, 4'd13, 4'd3);
        @(negedge clk);
        sign = 1'b1; dividend = W'($urandom); divisor = W'($urandom_range(1, 15));
        wait_done(lat);
        checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1 || lat != 6) begin
            errors++;
            $display("FAIL op_change: q=%0d r=%0d lat=%0d want 4 1 6", quotient, remainder, lat);
        end
        release_en();
    endtask

    task automatic test_abort();
        logic [W-1:0] q, r, eq, er, a, b;
        int lat;
        do_op(1'b0, 4'd14, 4'd4, q, r, lat);
        start(1'b0, 4'd9, 4'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd2) begin
                errors++;
                $display("FAIL abort_%0d: done=%b q=%0d r=%0d want 0 3 2", i, done, quotient, remainder);
            end
        end
        a = W'($urandom); b = W'($urandom);
        model(1'b1, a, b, eq, er);
        do_op(1'b1, a, b, q, r, lat);
        checks++;
        if (q !== eq || r !== er || lat != 6) begin
            errors++; $display("FAIL after_abort: q=%h r=%h lat=%0d want %h %h 6", q, r, lat, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r, eq, er;
        int lat;
        start(1'b1, 4'b1001, 4'd2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++; $display("FAIL reset_mid: done=%b q=%h r=%h want 0 0 0", done, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model(1'b0, 4'd11, 4'd5, eq, er);
        do_op(1'b0, 4'd11, 4'd5, q, r, lat);
        checks++;
        if (q !== eq || r !== er || lat != 6) begin
            errors++; $display("FAIL after_reset: q=%h r=%h lat=%0d want %h %h 6", q, r, lat, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        int order[512];
        int j, t;
        logic [W-1:0] q, r, eq, er, a, b;
        logic s;
        int lat;
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            s = order[i][8];
            a = W'(order[i] >> 4);
            b = W'(order[i]);
            model(s, a, b, eq, er);
            do_op(s, a, b, q, r, lat);
            checks++;
            if (q !== eq || r !== er || lat != 6) begin
                errors++;
                $display("FAIL sweep s=%b a=%h b=%h: q=%h r=%h lat=%0d want %h %h 6",
                         s, a, b, q, r, lat, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_div_zero();
        test_operand_change();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
